seat_booking_arbiter: RTL and testbench

// - Serialises seat book/cancel requests from two terminals onto one seat-occupancy map.
// - Arbitrates round-robin between the terminals and reports pass/fail per request.
// - Keeps the sold count and the full flag; the top level shows these on the 7-seg and LEDs.
// - Sits between the button/switch/PMOD front-end and the display/PMOD output logic of the booking system.

---
 rtl/seat_booking_if.sv | 30 +++
 rtl/seat_booking_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_seat_booking_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seat_booking_if.sv
// -----------------------------------------------------------------------------
// seat_booking_if
// Request/response bundle between the two booking terminals and the seat
// booking arbiter.
//   req_i    [1:0]  per-terminal request level, held until that terminal's ack
//   op_i     [1:0]  per-terminal op, 1=book, 0=cancel, stable while req is high
//   seat0_i  [3:0]  terminal 0 seat id, stable while req_i[0]=1
//   seat1_i  [3:0]  terminal 1 seat id, stable while req_i[1]=1
//   ack_o    [1:0]  one-hot single-cycle completion pulse per terminal
//   ok_o            verdict, meaningful only while ack_o is non-zero
// The master modport is the terminal side, the slave modport the arbiter.
// -----------------------------------------------------------------------------
interface seat_booking_if;
  logic [1:0] req_i;
  logic [1:0] op_i;
  logic [3:0] seat0_i;
  logic [3:0] seat1_i;
  logic [1:0] ack_o;
  logic       ok_o;

  modport master (
    output req_i, op_i, seat0_i, seat1_i,
    input  ack_o, ok_o
  );

  modport slave (
    input  req_i, op_i, seat0_i, seat1_i,
    output ack_o, ok_o
  );
endinterface

// File: rtl/seat_booking_arbiter.sv
// -----------------------------------------------------------------------------
// seat_booking_arbiter
// Serialises book/cancel requests from two terminals onto one seat-occupancy
// map. Terminals are served round-robin; each transaction takes three cycles
// (IDLE -> CHECK -> RESP) and ends with a one-cycle ack carrying a pass/fail
// verdict. A "release all seats" command empties the map via the CLR state.
//
// Parameters
//   N_SEATS  number of seats (2..16), seat ids 0..N_SEATS-1
//   CW       sold-count width, >= $clog2(N_SEATS+1)
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          terminal request/ack bundle (slave side)
//   clr_i        level "release all seats" command, wins over requests
//   busy_o       high in every state except IDLE
//   seat_map_o   bit i set = seat i sold
//   sold_cnt_o   number of sold seats
//   full_o       every seat sold
//   last_gnt_o   most recently granted terminal (1 after reset)
// -----------------------------------------------------------------------------
module seat_booking_arbiter #(
  parameter int N_SEATS = 16,
  parameter int CW      = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  seat_booking_if.slave      bus,
  input  logic               clr_i,
  output logic               busy_o,
  output logic [N_SEATS-1:0] seat_map_o,
  output logic [CW-1:0]      sold_cnt_o,
  output logic               full_o,
  output logic               last_gnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_RESP  = 2'd2,
    S_CLR   = 2'd3
  } state_t;

  state_t             state_q, state_d;

  // Latched transaction
  logic               gnt_q;
  logic               op_q;
  logic [3:0]         seat_q;
  logic               ok_q;

  // Booking state
  logic [N_SEATS-1:0] map_q;
  logic [CW-1:0]      cnt_q;
  logic               last_q;

  // Combinational helpers
  logic               take;
  logic               gnt_sel;
  logic               op_sel;
  logic [3:0]         seat_sel;
  logic [N_SEATS-1:0] seat_mask;
  logic               seat_valid;
  logic               seat_sold;
  logic               verdict;

  // ---------------------------------------------------------------------------
  // Round-robin pick: with both terminals requesting, the one not served last
  // wins; otherwise whichever terminal is requesting.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (bus.req_i == 2'b11) gnt_sel = ~last_q;
    else                    gnt_sel = bus.req_i[1];
  end

  assign op_sel   = gnt_sel ? bus.op_i[1] : bus.op_i[0];
  assign seat_sel = gnt_sel ? bus.seat1_i : bus.seat0_i;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    take    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (clr_i) begin
          state_d = S_CLR;
        end else if (|bus.req_i) begin
          state_d = S_CHECK;
          take    = 1'b1;
        end
      end
      S_CHECK: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      S_CLR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Seat decode: a one-hot mask of the latched seat id. An id at or beyond
  // N_SEATS matches no bit, which makes it invalid without indexing past the
  // map.
  // ---------------------------------------------------------------------------
  always_comb begin
    seat_mask = '0;
    for (int i = 0; i < N_SEATS; i++) begin
      seat_mask[i] = (seat_q == 4'(i));
    end
  end

  assign seat_valid = |seat_mask;
  assign seat_sold  = |(map_q & seat_mask);
  // Book needs a free seat, cancel needs a sold one.
  assign verdict    = seat_valid & (op_q ? ~seat_sold : seat_sold);

  // ---------------------------------------------------------------------------
  // Datapath. The map and count are written on the edge leaving CHECK, so the
  // new values appear in the same cycle as the ack.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the seat map is a plain flop vector, not a RAM, and must be
      // cleared by reset, so it sits in the reset branch with everything else.
      gnt_q  <= 1'b0;
      op_q   <= 1'b0;
      seat_q <= '0;
      ok_q   <= 1'b0;
      map_q  <= '0;
      cnt_q  <= '0;
      last_q <= 1'b1;
    end else begin
      if (take) begin
        gnt_q  <= gnt_sel;
        op_q   <= op_sel;
        seat_q <= seat_sel;
        last_q <= gnt_sel;
      end

      if (state_q == S_CHECK) begin
        ok_q <= verdict;
        if (verdict) begin
          if (op_q) begin
            map_q <= map_q | seat_mask;
            cnt_q <= cnt_q + CW'(1);
          end else begin
            map_q <= map_q & ~seat_mask;
            cnt_q <= cnt_q - CW'(1);
          end
        end
      end

      if (state_q == S_CLR) begin
        map_q <= '0;
        cnt_q <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.ack_o = 2'b00;
    if (state_q == S_RESP) bus.ack_o = gnt_q ? 2'b10 : 2'b01;
  end

  assign bus.ok_o   = (state_q == S_RESP) & ok_q;
  assign busy_o     = (state_q != S_IDLE);
  assign seat_map_o = map_q;
  assign sold_cnt_o = cnt_q;
  assign full_o     = (cnt_q == CW'(N_SEATS));
  assign last_gnt_o = last_q;

endmodule

// File: tb/tb_seat_booking_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seat_booking_arbiter
// Drives a 16-seat arbiter with directed scenarios followed by random traffic
// and compares it every cycle against a transaction-level model. A second,
// 12-seat instance covers out-of-range seat ids.
// -----------------------------------------------------------------------------
module tb_seat_booking_arbiter;
  localparam int N = 16;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr   = 1'b0;
  logic        busy, full, last;
  logic [15:0] map;
  logic [4:0]  sold;

  logic        busy12, full12, last12;
  logic [11:0] map12;
  logic [3:0]  sold12;

  int n_checks = 0;
  int n_err    = 0;

  seat_booking_if bus();
  seat_booking_if bus12();

  seat_booking_arbiter #(.N_SEATS(16), .CW(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr_i      (clr),
    .busy_o     (busy),
    .seat_map_o (map),
    .sold_cnt_o (sold),
    .full_o     (full),
    .last_gnt_o (last)
  );

  seat_booking_arbiter #(.N_SEATS(12), .CW(4)) dut12 (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus12),
    .clr_i      (1'b0),
    .busy_o     (busy12),
    .seat_map_o (map12),
    .sold_cnt_o (sold12),
    .full_o     (full12),
    .last_gnt_o (last12)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: seat array plus a countdown of cycles until the arbiter is
  // free again. A grant computes the verdict from the seat rules straight away
  // (nothing else can touch the seats meanwhile); two cycles later the seat
  // array changes and the ack is expected; a clear empties the seats one cycle
  // after it is accepted.
  // ---------------------------------------------------------------------------
  bit       m_seat [N];
  int       m_wait    = 0;
  bit       m_clr     = 0;
  int       m_term    = 0;
  bit       m_op      = 0;
  int       m_seatid  = 0;
  bit       m_verdict = 0;
  logic [1:0] exp_ack = 2'b00;
  bit       exp_ok    = 0;
  bit       exp_last  = 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_seat[i]) m_seat[i] = 1'b0;
      m_wait   = 0;
      m_clr    = 0;
      exp_ack  = 2'b00;
      exp_ok   = 0;
      exp_last = 1;
    end else begin
      exp_ack = 2'b00;
      exp_ok  = 0;
      if (m_wait == 0) begin
        if (clr) begin
          m_clr  = 1;
          m_wait = 1;
        end else if (bus.req_i != 2'b00) begin
          if (bus.req_i == 2'b11) m_term = exp_last ? 0 : 1;
          else                    m_term = bus.req_i[1] ? 1 : 0;
          m_op     = bus.op_i[m_term];
          m_seatid = (m_term == 1) ? int'(bus.seat1_i) : int'(bus.seat0_i);
          if (m_seatid >= N) m_verdict = 0;
          else if (m_op)     m_verdict = !m_seat[m_seatid];
          else               m_verdict = m_seat[m_seatid];
          exp_last = (m_term == 1);
          m_wait   = 2;
        end
      end else if (m_wait == 2) begin
        if (m_verdict) m_seat[m_seatid] = m_op;
        exp_ack = (m_term == 1) ? 2'b10 : 2'b01;
        exp_ok  = m_verdict;
        m_wait  = 1;
      end else begin
        if (m_clr) foreach (m_seat[i]) m_seat[i] = 1'b0;
        m_clr  = 0;
        m_wait = 0;
      end
    end
  end

  // Every-cycle comparison, away from the rising edge.
  always @(negedge clk) begin
    logic [15:0] em;
    int          es;
    em = '0;
    es = 0;
    for (int i = 0; i < N; i++) begin
      if (m_seat[i]) begin
        em[i] = 1'b1;
        es++;
      end
    end
    check("ack",      32'(bus.ack_o), 32'(exp_ack));
    check("ok",       32'(bus.ok_o),  32'(exp_ok));
    check("busy",     32'(busy),      32'(m_wait != 0));
    check("seat_map", 32'(map),       32'(em));
    check("sold_cnt", 32'(sold),      32'(es));
    check("full",     32'(full),      32'(es == N));
    check("last_gnt", 32'(last),      32'(exp_last));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Inputs change 2 time units after the rising edge; a
  // terminal drops its request in the cycle the ack is due.
  // ---------------------------------------------------------------------------
  logic [1:0] dropped = 2'b00;

  task automatic tick();
    @(posedge clk);
    #2;
    dropped = 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (exp_ack[k]) begin
        bus.req_i[k] = 1'b0;
        dropped[k]   = 1'b1;
      end
    end
  endtask

  task automatic launch(input int k, input bit op, input int seat);
    bus.req_i[k] = 1'b1;
    bus.op_i[k]  = op;
    if (k == 0) bus.seat0_i = 4'(seat);
    else        bus.seat1_i = 4'(seat);
  endtask

  task automatic wait_ack(input int k, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!exp_ack[k] && n <= 20);
    if (n > 20) begin
      n_checks++;
      n_err++;
      $display("FAIL ack_timeout: terminal %0d got no ack within 20 cycles, required 1", k);
    end
  endtask

  task automatic wait_ack12(input logic [1:0] want, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (bus12.ack_o == 2'b00 && n < 8);
    check("n12_ack", 32'(bus12.ack_o), 32'(want));
  endtask

  initial begin
    int n;
    bus.req_i   = 2'b00;
    bus.op_i    = 2'b00;
    bus.seat0_i = 4'd0;
    bus.seat1_i = 4'd0;
    bus12.req_i   = 2'b00;
    bus12.op_i    = 2'b00;
    bus12.seat0_i = 4'd0;
    bus12.seat1_i = 4'd0;

    repeat (2) @(posedge clk);
    #2;
    check("rst_map",  32'(map),  32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_last", 32'(last), 32'h1);
    rst_n = 1'b1;

    // 12-seat instance: seat 13 does not exist, seat 11 does.
    bus12.req_i   = 2'b01;
    bus12.op_i    = 2'b01;
    bus12.seat0_i = 4'd13;
    wait_ack12(2'b01, n);
    check("n12_bad_ok",  32'(bus12.ok_o), 32'h0);
    check("n12_bad_map", 32'(map12),      32'h0);
    bus12.req_i = 2'b00;
    @(posedge clk);
    #2;
    bus12.req_i   = 2'b10;
    bus12.op_i    = 2'b10;
    bus12.seat1_i = 4'd11;
    wait_ack12(2'b10, n);
    check("n12_ok",   32'(bus12.ok_o), 32'h1);
    check("n12_map",  32'(map12),      32'h800);
    check("n12_sold", 32'(sold12),     32'h1);
    bus12.req_i = 2'b00;
    tick();

    // First booking: ack exactly two cycles after the request is sampled.
    launch(0, 1'b1, 3);
    wait_ack(0, n);
    check("t1_latency", 32'(n),         32'd2);
    check("t1_ack",     32'(bus.ack_o), 32'h1);
    check("t1_ok",      32'(bus.ok_o),  32'h1);
    check("t1_map",     32'(map),       32'h0008);
    check("t1_sold",    32'(sold),      32'h1);

    // Cancel of a free seat is rejected and leaves the map alone.
    launch(1, 1'b0, 7);
    wait_ack(1, n);
    check("cx_ok",   32'(bus.ok_o), 32'h0);
    check("cx_map",  32'(map),      32'h0008);
    check("cx_last", 32'(last),     32'h1);
    tick();

    // Both terminals book seat 5: terminal 0 first, terminal 1 rejected.
    launch(0, 1'b1, 5);
    launch(1, 1'b1, 5);
    wait_ack(0, n);
    check("rr_ack0", 32'(bus.ack_o), 32'h1);
    check("rr_ok0",  32'(bus.ok_o),  32'h1);
    wait_ack(1, n);
    check("rr_ack1", 32'(bus.ack_o), 32'h2);
    check("rr_ok1",  32'(bus.ok_o),  32'h0);
    check("rr_sold", 32'(sold),      32'h2);
    tick();

    // Clear, then fill every seat.
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    check("clr_map", 32'(map), 32'h0);
    for (int s = 0; s < N; s++) begin
      launch(0, 1'b1, s);
      wait_ack(0, n);
      tick();
    end
    check("fill_full", 32'(full), 32'h1);
    check("fill_sold", 32'(sold), 32'd16);
    launch(1, 1'b1, 3);
    wait_ack(1, n);
    check("fill_17th_ok", 32'(bus.ok_o), 32'h0);
    tick();
    launch(0, 1'b0, 0);
    wait_ack(0, n);
    check("unfill_ok",   32'(bus.ok_o), 32'h1);
    check("unfill_sold", 32'(sold),     32'd15);
    check("unfill_full", 32'(full),     32'h0);
    tick();

    // Clear raised during CHECK: the pending ack still arrives, then the clear.
    launch(1, 1'b1, 0);
    tick();
    clr = 1'b1;
    wait_ack(1, n);
    check("clrx_ack", 32'(bus.ack_o), 32'h2);
    check("clrx_ok",  32'(bus.ok_o),  32'h1);
    tick();
    tick();
    clr = 1'b0;
    tick();
    check("clrx_map",  32'(map),       32'h0);
    check("clrx_sold", 32'(sold),      32'h0);
    check("clrx_ack0", 32'(bus.ack_o), 32'h0);

    // Reset during CHECK aborts the transaction; terminal 0 wins afterwards.
    launch(0, 1'b1, 4);
    tick();
    launch(1, 1'b1, 6);
    rst_n = 1'b0;
    #1;
    check("rstx_ack",  32'(bus.ack_o), 32'h0);
    check("rstx_busy", 32'(busy),      32'h0);
    check("rstx_last", 32'(last),      32'h1);
    tick();
    check("rstx_ack2", 32'(bus.ack_o), 32'h0);
    rst_n = 1'b1;
    wait_ack(0, n);
    check("rstx_first", 32'(bus.ack_o), 32'h1);
    check("rstx_ok",    32'(bus.ok_o),  32'h1);
    wait_ack(1, n);
    check("rstx_map",   32'(map),       32'h0050);
    tick();

    // Random traffic with occasional clear bursts.
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        if (!bus.req_i[k] && !dropped[k] && $urandom_range(0, 2) == 0)
          launch(k, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      end
      if (clr) clr = ($urandom_range(0, 1) == 1);
      else     clr = ($urandom_range(0, 29) == 0);
    end

    clr = 1'b0;
    repeat (8) tick();
    bus.req_i = 2'b00;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
